issue_scheduler: RTL

//   Parametrised issue scheduler for the Tomasulo back end. Each cycle it picks
//   at most one ready reservation-station channel and grants issue to its

---
 rtl/issue_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: picks at most one ready reservation-station channel per cycle,
// grants it issue to its functional unit, tracks the in-flight op by ROB tag and
// announces its completion to the CDB arbiter. The single CDB writeback slot is
// reserved at issue time, so two ops never complete in the same cycle.
//
// Ports
//   clk           clock
//   reset         synchronous, active-low reset
//   instr_ready   per-channel ready op
//   rob_tag_in    per-channel ROB tag, channel 0 in the LSBs
//   issue_grant   one-hot or zero combinational grant
//   fu_busy       channel cannot accept a new op
//   done_valid    one-cycle completion strobe
//   done_tag      ROB tag of the completing op
//   done_ch       channel of the completing op
//   inflight_cnt  number of valid slots
//   flush         mispredict recovery, present only with ISSUE_FLUSH_EN defined
//
// Build option: define ISSUE_FLUSH_EN to add the flush port.
//
// Timing: an op granted in cycle G occupies its slot in cycles G+1..G+LAT and
// completes (done_valid high) in cycle G+LAT+1, the cycle its fu_busy drops.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module issue_scheduler #(
  parameter int unsigned         NUM_CH     = 4,
  parameter int unsigned         TAG_W      = `ROB_TAG_LEN,
  parameter logic [NUM_CH*4-1:0] LAT        = 16'h8411,
  parameter int unsigned         PIPE_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   instr_ready,
  input  logic [NUM_CH*TAG_W-1:0]             rob_tag_in,
`ifdef ISSUE_FLUSH_EN
  input  logic                                flush,
`endif
  output logic [NUM_CH-1:0]                   issue_grant,
  output logic [NUM_CH-1:0]                   fu_busy,
  output logic                                done_valid,
  output logic [TAG_W-1:0]                    done_tag,
  output logic [$clog2(NUM_CH)-1:0]           done_ch,
  output logic [$clog2(NUM_CH+PIPE_DEPTH):0]  inflight_cnt
);

  localparam int unsigned CH_W      = $clog2(NUM_CH);
  localparam int unsigned CNT_W     = $clog2(NUM_CH + PIPE_DEPTH) + 1;
  localparam int unsigned LAST      = NUM_CH - 1;
  localparam int unsigned PIPE_BASE = NUM_CH - 1;
  localparam int unsigned NUM_SLOTS = NUM_CH - 1 + PIPE_DEPTH;

  // Elaboration-time parameter checks
  if (NUM_CH < 2) begin : g_num_ch_err
    $error("issue_scheduler: NUM_CH must be at least 2");
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lat_chk
    if (LAT[g*4 +: 4] == 4'd0) begin : g_err
      $error("issue_scheduler: LAT of channel %0d is zero", g);
    end
  end
  if (PIPE_DEPTH < int'(LAT[LAST*4 +: 4])) begin : g_depth_err
    $error("issue_scheduler: PIPE_DEPTH smaller than pipelined channel latency");
  end

  function automatic logic [3:0] lat_of(input int unsigned ch);
    return LAT[ch*4 +: 4];
  endfunction

  // Slots 0..NUM_CH-2 belong to the non-pipelined channels; the rest form the pipe.
  logic             slot_valid_q [NUM_SLOTS];
  logic             slot_valid_d [NUM_SLOTS];
  logic [TAG_W-1:0] slot_tag_q   [NUM_SLOTS];
  logic [TAG_W-1:0] slot_tag_d   [NUM_SLOTS];
  logic [CH_W-1:0]  slot_ch_q    [NUM_SLOTS];
  logic [CH_W-1:0]  slot_ch_d    [NUM_SLOTS];
  logic [3:0]       slot_cnt_q   [NUM_SLOTS];
  logic [3:0]       slot_cnt_d   [NUM_SLOTS];

  logic             done_valid_q, done_valid_d;
  logic [TAG_W-1:0] done_tag_q, done_tag_d;
  logic [CH_W-1:0]  done_ch_q, done_ch_d;

  logic             flush_act;
  logic             pipe_any_free;
  int unsigned      pipe_free_idx;
  logic             grant_any;
  int unsigned      grant_ch;

`ifdef ISSUE_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Lowest-index free pipe slot
  always_comb begin
    pipe_any_free = 1'b0;
    pipe_free_idx = 0;
    for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
      if (!slot_valid_q[PIPE_BASE+s] && !pipe_any_free) begin
        pipe_any_free = 1'b1;
        pipe_free_idx = s;
      end
    end
  end

  // Fixed-priority grant. The collision check compares against the count each slot
  // will hold after this edge (cnt-1), which is what the new op's LAT competes with.
  always_comb begin
    logic ch_free;
    logic collide;
    issue_grant = '0;
    grant_any   = 1'b0;
    grant_ch    = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_free = (i < LAST) ? !slot_valid_q[i] : pipe_any_free;
      collide = 1'b0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (slot_valid_q[s] && ({1'b0, slot_cnt_q[s]} == ({1'b0, lat_of(i)} + 5'd1))) begin
          collide = 1'b1;
        end
      end
      if (reset && !flush_act && instr_ready[i] && ch_free && !collide && !grant_any) begin
        issue_grant[i] = 1'b1;
        grant_any      = 1'b1;
        grant_ch       = i;
      end
    end
  end

  // Slot countdown, completion and fill
  always_comb begin
    int unsigned fill_idx;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    done_ch_d    = done_ch_q;
    fill_idx     = 0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      slot_valid_d[s] = slot_valid_q[s];
      slot_tag_d[s]   = slot_tag_q[s];
      slot_ch_d[s]    = slot_ch_q[s];
      slot_cnt_d[s]   = slot_cnt_q[s];
      if (slot_valid_q[s]) begin
        if (slot_cnt_q[s] == 4'd1) begin
          slot_valid_d[s] = 1'b0;
          done_valid_d    = 1'b1;
          done_tag_d      = slot_tag_q[s];
          done_ch_d       = slot_ch_q[s];
        end else begin
          slot_cnt_d[s] = slot_cnt_q[s] - 4'd1;
        end
      end
    end
    if (grant_any) begin
      fill_idx               = (grant_ch < LAST) ? grant_ch : PIPE_BASE + pipe_free_idx;
      slot_valid_d[fill_idx] = 1'b1;
      slot_tag_d[fill_idx]   = rob_tag_in[grant_ch*TAG_W +: TAG_W];
      slot_ch_d[fill_idx]    = CH_W'(grant_ch);
      slot_cnt_d[fill_idx]   = lat_of(grant_ch);
    end
    // Flush beats a completion due at the same edge
    if (flush_act) begin
      done_valid_d = 1'b0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        slot_valid_d[s] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        slot_valid_q[s] <= 1'b0;
        slot_tag_q[s]   <= '0;
        slot_ch_q[s]    <= '0;
        slot_cnt_q[s]   <= '0;
      end
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      done_ch_q    <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        slot_valid_q[s] <= slot_valid_d[s];
        slot_tag_q[s]   <= slot_tag_d[s];
        slot_ch_q[s]    <= slot_ch_d[s];
        slot_cnt_q[s]   <= slot_cnt_d[s];
      end
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      done_ch_q    <= done_ch_d;
    end
  end

  always_comb begin
    fu_busy      = '0;
    inflight_cnt = '0;
    for (int unsigned i = 0; i < LAST; i++) begin
      fu_busy[i] = slot_valid_q[i];
    end
    fu_busy[LAST] = !pipe_any_free;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      inflight_cnt = inflight_cnt + CNT_W'(slot_valid_q[s]);
    end
  end

  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;
  assign done_ch    = done_ch_q;

endmodule
